// File: rtl/schmitt_scan_pkg.sv
// Shared defaults, types and the integrator/threshold step used by the
// six-line Schmitt-trigger scan conditioner.
package schmitt_scan_pkg;

    localparam int unsigned DEF_CHANNELS = 6;
    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned DEF_CNT_MAX  = 255;
    localparam int unsigned DEF_TH_HI    = 192;
    localparam int unsigned DEF_TH_LO    = 64;

    typedef logic [DEF_CNT_W-1:0]             cnt_t;
    typedef logic [$clog2(DEF_CHANNELS)-1:0] ch_idx_t;

    typedef struct packed {
        logic [31:0] cnt;
        logic        state;
    } slot_next_t;

    // Saturating up/down integrator followed by a two-threshold hysteresis latch.
    function automatic slot_next_t slot_next(
        input logic [31:0] cnt,
        input logic        state,
        input logic        sync,
        input logic [31:0] cnt_max,
        input logic [31:0] th_hi,
        input logic [31:0] th_lo
    );
        slot_next_t r;
        r.cnt   = cnt;
        r.state = state;
        if (sync && (cnt < cnt_max))
            r.cnt = cnt + 32'd1;
        else if (!sync && (cnt != 32'd0))
            r.cnt = cnt - 32'd1;
        if (r.cnt >= th_hi)
            r.state = 1'b1;
        else if (r.cnt <= th_lo)
            r.state = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/schmitt_scan_conditioner_slot_update.sv
// Combinational integrator/threshold datapath shared by all channels;
// the top muxes the visited channel's count, state and sync bit into it.
module schmitt_slot_update
    import schmitt_scan_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned CNT_MAX = DEF_CNT_MAX,
    parameter int unsigned TH_HI   = DEF_TH_HI,
    parameter int unsigned TH_LO   = DEF_TH_LO
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             state,
    input  logic             sync,
    output logic [CNT_W-1:0] next_cnt,
    output logic             next_state
);

    slot_next_t r;

    always_comb begin
        r = slot_next(32'(cnt), state, sync, 32'(CNT_MAX), 32'(TH_HI), 32'(TH_LO));
    end

    assign next_cnt   = CNT_W'(r.cnt);
    assign next_state = r.state;

endmodule

// File: rtl/schmitt_scan_conditioner.sv
// Six-line Schmitt-trigger input conditioner: 2-flop synchronizer, prescaled
// round-robin scan and one shared integrator/threshold slot per cen-slot.
module schmitt_scan_conditioner
    import schmitt_scan_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned PRESCALE = 48,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned CNT_MAX  = DEF_CNT_MAX,
    parameter int unsigned TH_HI    = DEF_TH_HI,
    parameter int unsigned TH_LO    = DEF_TH_LO,
    parameter bit          INVERT   = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cen,
    input  logic [CHANNELS-1:0] in_raw,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] edge_strobe,
    output logic                scan_done
);

    localparam int unsigned PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(CHANNELS - 1);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    if (!((TH_LO < TH_HI) && (TH_HI <= CNT_MAX) && ((CNT_MAX >> CNT_W) == 0))) begin : g_bad_thresholds
        $error("schmitt_scan_conditioner: need TH_LO < TH_HI <= CNT_MAX < 2**CNT_W");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("schmitt_scan_conditioner: PRESCALE must be >= 1");
    end
    if ((CHANNELS < 1) || (CHANNELS > 8)) begin : g_bad_channels
        $error("schmitt_scan_conditioner: CHANNELS must be 1..8");
    end

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] state;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [PS_W-1:0]     presc;
    logic [PTR_W-1:0]    ptr;

    logic             slot_tick;
    logic [CNT_W-1:0] next_cnt;
    logic             next_state;
    logic             next_out;

    assign slot_tick = cen && (presc == PS_LAST);
    assign next_out  = next_state ^ INVERT;

    schmitt_slot_update #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX),
        .TH_HI   (TH_HI),
        .TH_LO   (TH_LO)
    ) u_slot (
        .cnt        (cnt[ptr]),
        .state      (state[ptr]),
        .sync       (sync2[ptr]),
        .next_cnt   (next_cnt),
        .next_state (next_state)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            state       <= '0;
            presc       <= '0;
            ptr         <= '0;
            out         <= {CHANNELS{INVERT}};
            edge_strobe <= '0;
            scan_done   <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++)
                cnt[i] <= '0;
        end else begin
            sync1       <= in_raw;
            sync2       <= sync1;
            edge_strobe <= '0;
            scan_done   <= 1'b0;
            if (slot_tick) begin
                presc              <= '0;
                cnt[ptr]           <= next_cnt;
                state[ptr]         <= next_state;
                out[ptr]           <= next_out;
                edge_strobe[ptr]   <= (next_out != out[ptr]);
                scan_done          <= (ptr == LAST_CH);
                ptr                <= (ptr == LAST_CH) ? '0 : ptr + 1'b1;
            end else if (cen) begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_schmitt_scan_conditioner.sv
// Scoreboard bench: stimulus pushes expected edge events (strobe, out, scan index),
// a negedge monitor pops and compares them and checks out is otherwise stable.
module tb_schmitt_scan_conditioner;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cen = 1'b1;
    logic [5:0] in_raw = '0;
    logic [5:0] out;
    logic [5:0] edge_strobe;
    logic       scan_done;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned scan_cnt = 0;
    logic [5:0]  last_out = 6'h3F;

    typedef struct {
        logic [5:0]  strobe;
        logic [5:0]  out;
        int unsigned scan;
    } exp_t;

    exp_t sb[$];

    schmitt_scan_conditioner #(
        .CHANNELS (6),
        .PRESCALE (2),
        .CNT_W    (8),
        .CNT_MAX  (5),
        .TH_HI    (4),
        .TH_LO    (1),
        .INVERT   (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cen         (cen),
        .in_raw      (in_raw),
        .out         (out),
        .edge_strobe (edge_strobe),
        .scan_done   (scan_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [5:0] strobe, input logic [5:0] o, input int unsigned scan);
        exp_t e;
        e.strobe = strobe;
        e.out    = o;
        e.scan   = scan;
        sb.push_back(e);
    endtask

    task automatic wait_scan_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = scan_done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout: no scan_done within 40 clk at %0t", $time);
        end
        #1;
    endtask

    task automatic count_to_scan(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = scan_done;
        end
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            last_out = 6'h3F;
        end else begin
            if (scan_done) scan_cnt++;
            if (edge_strobe != 6'h00) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_edge: strobe %0h out %0h, nothing expected at %0t",
                             edge_strobe, out, $time);
                end else begin
                    e = sb.pop_front();
                    check("edge_strobe", 32'(edge_strobe), 32'(e.strobe));
                    check("edge_out", 32'(out), 32'(e.out));
                    check("edge_scan_index", scan_cnt, e.scan);
                end
                last_out = out;
            end else begin
                check("out_stable", 32'(out), 32'(last_out));
            end
        end
    end

    initial begin
        int n;
        int unsigned k;
        int unsigned s;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_out", 32'(out), 32'h3F);
        check("reset_strobe", 32'(edge_strobe), 32'h0);
        check("reset_scan_done", 32'(scan_done), 32'h0);
        #1 reset_n = 1'b1;

        // scan_done period: first after 12 clk, then every 12 clk
        count_to_scan(n);
        check("first_scan_period", 32'(n), 32'd12);
        count_to_scan(n);
        check("scan_period", 32'(n), 32'd12);

        // Step ch0 and ch2 high: ch2 visits see it in the current scan, ch0 one scan later
        k = scan_cnt;
        in_raw[0] = 1'b1;
        in_raw[2] = 1'b1;
        push(6'h04, 6'h3B, k + 3);
        push(6'h01, 6'h3A, k + 4);
        repeat (6) wait_scan_done();

        // Hysteresis on ch2 from saturation (5): 4, 3, glitch->4, 3, 2, 1 -> out[2] back to 1
        k = scan_cnt;
        in_raw[2] = 1'b0;
        push(6'h04, 6'h3E, k + 5);
        repeat (2) wait_scan_done();
        in_raw[2] = 1'b1;
        repeat (6) @(negedge clk);
        in_raw[2] = 1'b0;
        repeat (5) wait_scan_done();
        check("queue_drained_hyst", sb.size(), 32'd0);

        // ch3 toggling every 6 clk is always sampled low by its 12-clk visits
        for (int i = 0; i < 8; i++) begin
            in_raw[3] = (i % 2 == 1);
            repeat (6) @(negedge clk);
        end
        in_raw[3] = 1'b0;
        repeat (2) wait_scan_done();
        check("ch3_out_held", 32'(out[3]), 32'd1);

        // cen low mid-scan (after ch1 update): everything freezes, then resumes at ch2
        wait_scan_done();
        repeat (5) @(negedge clk);
        cen = 1'b0;
        s = scan_cnt;
        repeat (50) @(negedge clk);
        check("freeze_scan_done", scan_cnt, s);
        check("freeze_out", 32'(out), 32'h3E);
        cen = 1'b1;
        count_to_scan(n);
        check("resume_to_scan_done", 32'(n), 32'd7);

        // Asynchronous reset between edges with out[0]=0
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_out", 32'(out), 32'h3F);
        check("async_reset_strobe", 32'(edge_strobe), 32'h0);
        check("async_reset_scan_done", 32'(scan_done), 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Counts cleared: ch0 (in_raw still 1) needs 4 fresh increments to flip
        wait_scan_done();
        k = scan_cnt;
        push(6'h01, 6'h3E, k + 3);
        repeat (5) wait_scan_done();
        check("queue_drained_end", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
